// File: rtl/aes_in_loader_pkg.sv
// Shared widths, state encoding and phase helper for the AES input loader.
// Optional feature macro used by the loader: KEY_REUSE_EN.
package aes_in_loader_pkg;

    localparam int AES_W  = 128;
    localparam int WORD_W = 32;
    localparam int NWORDS = AES_W / WORD_W;

    localparam logic [1:0] S_LOAD_KEY  = 2'd0;
    localparam logic [1:0] S_LOAD_DATA = 2'd1;
    localparam logic [1:0] S_LAUNCH    = 2'd2;
    localparam logic [1:0] S_WAIT      = 2'd3;

    typedef enum logic [1:0] {
        ST_LOAD_KEY  = S_LOAD_KEY,
        ST_LOAD_DATA = S_LOAD_DATA,
        ST_LAUNCH    = S_LAUNCH,
        ST_WAIT      = S_WAIT
    } state_t;

    // True when the word tag matches the operand currently being loaded.
    function automatic logic tag_ok(input state_t st, input logic is_key);
        case (st)
            ST_LOAD_KEY:  return is_key;
            ST_LOAD_DATA: return ~is_key;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/aes_in_loader_word_packer.sv
// Packs four 32-bit words MSW-first into a 128-bit operand register;
// wrap flags the write of the last word.
module aes_in_loader_word_packer
    import aes_in_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [WORD_W-1:0]   din,
    output logic [AES_W-1:0]    data,
    output logic                wrap
);

    logic [1:0]         cnt_r;
    logic [AES_W-1:0]   data_r;

    // Slot counter and word insertion; untouched slots keep their old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= 2'd0;
            data_r <= {AES_W{1'b0}};
        end else if (we) begin
            cnt_r <= cnt_r + 2'd1;
            case (cnt_r)
                2'd0:    data_r[127:96] <= din;
                2'd1:    data_r[95:64]  <= din;
                2'd2:    data_r[63:32]  <= din;
                2'd3:    data_r[31:0]   <= din;
                default: data_r         <= data_r;
            endcase
        end else begin
            cnt_r  <= cnt_r;
            data_r <= data_r;
        end
    end

    assign data = data_r;
    assign wrap = we & (cnt_r == 2'(NWORDS - 1));

endmodule

// File: rtl/aes_in_loader.sv
// Assembles key and plaintext from a tagged word stream, launches the AES core
// and holds operands until done. Optional macro: KEY_REUSE_EN (adds key_hold).
module aes_in_loader
    import aes_in_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_W-1:0]   din,
    input  logic                din_valid,
    input  logic                din_is_key,
    output logic                din_ready,
    output logic [AES_W-1:0]    blk_out,
    output logic [AES_W-1:0]    key_out,
    output logic                start,
    input  logic                done,
`ifdef KEY_REUSE_EN
    input  logic                key_hold,
`endif
    output logic                busy,
    output logic                err
);

    state_t state_r;
    logic   start_r;
    logic   busy_r;
    logic   err_r;
    logic   accept_s;
    logic   match_s;
    logic   key_we_s;
    logic   blk_we_s;
    logic   key_wrap_s;
    logic   blk_wrap_s;
    state_t after_done_s;

    assign din_ready = ~reset & ((state_r == ST_LOAD_KEY) | (state_r == ST_LOAD_DATA));
    assign accept_s  = din_valid & din_ready;
    assign match_s   = tag_ok(state_r, din_is_key);
    assign key_we_s  = accept_s & match_s & (state_r == ST_LOAD_KEY);
    assign blk_we_s  = accept_s & match_s & (state_r == ST_LOAD_DATA);

`ifdef KEY_REUSE_EN
    assign after_done_s = key_hold ? ST_LOAD_DATA : ST_LOAD_KEY;
`else
    assign after_done_s = ST_LOAD_KEY;
`endif

    aes_in_loader_word_packer u_key_packer (
        .clk   (clk),
        .reset (reset),
        .we    (key_we_s),
        .din   (din),
        .data  (key_out),
        .wrap  (key_wrap_s)
    );

    aes_in_loader_word_packer u_blk_packer (
        .clk   (clk),
        .reset (reset),
        .we    (blk_we_s),
        .din   (din),
        .data  (blk_out),
        .wrap  (blk_wrap_s)
    );

    // Control FSM: start is a registered one-cycle pulse coinciding with LAUNCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_LOAD_KEY;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (accept_s & ~match_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            case (state_r)
                ST_LOAD_KEY: begin
                    start_r <= 1'b0;
                    busy_r  <= busy_r | accept_s;
                    state_r <= key_wrap_s ? ST_LOAD_DATA : ST_LOAD_KEY;
                end
                ST_LOAD_DATA: begin
                    start_r <= blk_wrap_s;
                    busy_r  <= busy_r | accept_s;
                    state_r <= blk_wrap_s ? ST_LAUNCH : ST_LOAD_DATA;
                end
                ST_LAUNCH: begin
                    // done here is ignored: the core needs at least one cycle
                    start_r <= 1'b0;
                    busy_r  <= busy_r;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    start_r <= 1'b0;
                    if (done) begin
                        busy_r  <= 1'b0;
                        state_r <= after_done_s;
                    end else begin
                        busy_r  <= busy_r;
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    start_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_LOAD_KEY;
                end
            endcase
        end
    end

    assign start = start_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule

// File: tb/tb_aes_in_loader.sv
// Directed self-checking bench for aes_in_loader (FIPS-197 operands, bubbles,
// tag mismatch, reset mid-load, done timing, and KEY_REUSE_EN when defined).
module tb_aes_in_loader;

    localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_ALT  = 128'h11111111222222223333333344444444;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  din;
    logic         din_valid;
    logic         din_is_key;
    logic         din_ready;
    logic [127:0] blk_out;
    logic [127:0] key_out;
    logic         start;
    logic         done;
    logic         busy;
    logic         err;
`ifdef KEY_REUSE_EN
    logic         key_hold;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes_in_loader dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_is_key (din_is_key),
        .din_ready  (din_ready),
        .blk_out    (blk_out),
        .key_out    (key_out),
        .start      (start),
        .done       (done),
`ifdef KEY_REUSE_EN
        .key_hold   (key_hold),
`endif
        .busy       (busy),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word for a single cycle; the loader must be ready for it.
    task automatic send(input logic [31:0] w, input logic k);
        din        = w;
        din_is_key = k;
        din_valid  = 1'b1;
        chk("din_ready_on_send", 128'(din_ready), 128'd1);
        tick();
        din_valid  = 1'b0;
    endtask

    task automatic load(input logic [127:0] key, input logic [127:0] blk, input logic bubble);
        for (int i = 0; i < 4; i++) begin
            send(key[127-32*i -: 32], 1'b1);
            if (bubble) tick();
        end
        for (int i = 0; i < 4; i++) begin
            send(blk[127-32*i -: 32], 1'b0);
            if (bubble && i < 3) tick();
        end
    endtask

    // Called in the LAUNCH cycle; walks through WAIT and returns via done.
    task automatic finish_block(input logic [127:0] key, input logic [127:0] blk);
        chk("start_after_8th", 128'(start), 128'd1);
        chk("ready_in_launch", 128'(din_ready), 128'd0);
        chk("busy_in_launch", 128'(busy), 128'd1);
        chk("key_out", key_out, key);
        chk("blk_out", blk_out, blk);
        tick();
        chk("start_one_cycle", 128'(start), 128'd0);
        repeat (3) tick();
        chk("ready_in_wait", 128'(din_ready), 128'd0);
        chk("key_stable_wait", key_out, key);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("busy_after_done", 128'(busy), 128'd0);
        chk("ready_after_done", 128'(din_ready), 128'd1);
    endtask

    initial begin
        reset = 1'b1; din = 32'd0; din_valid = 1'b0; din_is_key = 1'b0; done = 1'b0;
`ifdef KEY_REUSE_EN
        key_hold = 1'b0;
`endif
        repeat (2) tick();
        chk("rst_ready", 128'(din_ready), 128'd0);
        chk("rst_key", key_out, 128'd0);
        chk("rst_blk", blk_out, 128'd0);
        chk("rst_start_busy_err", {125'd0, start, busy, err}, 128'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 128'(din_ready), 128'd1);

        // FIPS-197 load; done pulsed during LAUNCH must be ignored
        for (int i = 0; i < 4; i++) send(K_FIPS[127-32*i -: 32], 1'b1);
        chk("busy_after_key", 128'(busy), 128'd1);
        chk("key_loaded", key_out, K_FIPS);
        for (int i = 0; i < 4; i++) send(P_FIPS[127-32*i -: 32], 1'b0);
        chk("start_after_8th", 128'(start), 128'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("done_in_launch_ignored", 128'(din_ready), 128'd0);
        chk("busy_after_launch_done", 128'(busy), 128'd1);
        chk("start_dropped", 128'(start), 128'd0);
        repeat (5) tick();
        chk("still_wait", 128'(din_ready), 128'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("busy_cleared", 128'(busy), 128'd0);
        chk("ready_back", 128'(din_ready), 128'd1);
        chk("err_clean", 128'(err), 128'd0);
        chk("key_kept", key_out, K_FIPS);

        // Same stream with valid toggling
        load(K_FIPS, P_FIPS, 1'b1);
        finish_block(K_FIPS, P_FIPS);

        // Tag mismatch in LOAD_KEY
        send(32'hA5A5A5A5, 1'b0);
        chk("err_set", 128'(err), 128'd1);
        chk("key_not_written", key_out, K_FIPS);
        for (int i = 0; i < 4; i++) send(K_ALT[127-32*i -: 32], 1'b1);
        chk("key_excl_a5", key_out, K_ALT);
        for (int i = 0; i < 4; i++) send(P_FIPS[127-32*i -: 32], 1'b0);
        finish_block(K_ALT, P_FIPS);
        chk("err_sticky", 128'(err), 128'd1);

        // Reset after two key words, then a fresh load
        send(32'hdeadbeef, 1'b1);
        send(32'hcafef00d, 1'b1);
        reset = 1'b1;
        #2;
        chk("midrst_ready", 128'(din_ready), 128'd0);
        reset = 1'b0;
        #1;
        chk("midrst_key", key_out, 128'd0);
        chk("midrst_blk", blk_out, 128'd0);
        chk("midrst_flags", {125'd0, start, busy, err}, 128'd0);
        chk("midrst_ready_after", 128'(din_ready), 128'd1);
        tick();
        load(K_FIPS, P_FIPS, 1'b0);
        finish_block(K_FIPS, P_FIPS);

`ifdef KEY_REUSE_EN
        // Back-to-back block under the held key
        load(K_FIPS, P_FIPS, 1'b0);
        tick();
        key_hold = 1'b1;
        done     = 1'b1;
        tick();
        done     = 1'b0;
        key_hold = 1'b0;
        chk("reuse_busy", 128'(busy), 128'd0);
        send(32'hffeeddcc, 1'b0);
        send(32'hbbaa9988, 1'b0);
        send(32'h77665544, 1'b0);
        send(32'h33221100, 1'b0);
        chk("reuse_err", 128'(err), 128'd0);
        finish_block(K_FIPS, 128'hffeeddccbbaa99887766554433221100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
